// File: rtl/bsg_mul_adapter_pkg.sv
// Shared definitions for the multiplier op adapter: op codes and controller states.
package bsg_mul_adapter_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = OP_MUL,
    MUL_OP_MULH   = OP_MULH,
    MUL_OP_MULHSU = OP_MULHSU,
    MUL_OP_MULHU  = OP_MULHU
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CORR,
    S_OUT
  } state_e;

endpackage

// File: rtl/bsg_mul_op_adapter.sv
// Adapts RISC-V style MUL/MULH/MULHSU/MULHU requests onto a plain signed/unsigned
// iterative multiplier, one request in flight at a time.
module bsg_mul_op_adapter
  import bsg_mul_adapter_pkg::*;
#(
  parameter int width_p     = 64,
  parameter int tag_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,

  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [1:0]             op_i,
  input  logic [width_p-1:0]     opA_i,
  input  logic [width_p-1:0]     opB_i,
  input  logic [tag_width_p-1:0] tag_i,

  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  output logic [tag_width_p-1:0] tag_o,
  input  logic                   yumi_i,

  input  logic                   mul_ready_i,
  output logic                   mul_v_o,
  output logic [width_p-1:0]     mul_opA_o,
  output logic [width_p-1:0]     mul_opB_o,
  output logic                   mul_signed_o,

  input  logic                   mul_v_i,
  input  logic [2*width_p-1:0]   mul_result_i,
  output logic                   mul_yumi_o
);

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [width_p-1:0]     opa_q, opa_d;
  logic [width_p-1:0]     opb_q, opb_d;
  logic [tag_width_p-1:0] tag_q, tag_d;
  logic [width_p-1:0]     result_q, result_d;

  // NOTE: the datapath registers are reset too, because data_o, tag_o and the
  // multiplier operands must read as zero while reset is held.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    tag_d      = tag_q;
    result_d   = result_q;
    ready_o    = 1'b0;
    mul_v_o    = 1'b0;
    mul_yumi_o = 1'b0;
    v_o        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          op_d    = op_i;
          opa_d   = opA_i;
          opb_d   = opB_i;
          tag_d   = tag_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_v_o = 1'b1;
        if (mul_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        mul_yumi_o = mul_v_i;
        if (mul_v_i) begin
          result_d = (op_q == OP_MUL) ? mul_result_i[width_p-1:0]
                                      : mul_result_i[2*width_p-1:width_p];
          state_d  = (op_q == OP_MULHSU) ? S_CORR : S_OUT;
        end
      end
      S_CORR: begin
        // The multiplier ran unsigned; a negative A contributed +2^w*B too much,
        // which is exactly B in the high half.
        result_d = result_q - (opa_q[width_p-1] ? opb_q : '0);
        state_d  = S_OUT;
      end
      S_OUT: begin
        v_o = 1'b1;
        if (yumi_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_opA_o    = opa_q;
  assign mul_opB_o    = opb_q;
  assign mul_signed_o = (op_q == OP_MULH);
  assign data_o       = result_q;
  assign tag_o        = tag_q;

endmodule

// File: tb/tb_bsg_mul_op_adapter.sv
// Self-checking bench for bsg_mul_op_adapter: directed corner cases, backpressure,
// mid-operation reset and randomized requests against an arithmetic reference.
module tb_bsg_mul_op_adapter;

  localparam int W = 64;
  localparam int T = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic           v_i, ready_o;
  logic [1:0]     op_i;
  logic [W-1:0]   opA_i, opB_i;
  logic [T-1:0]   tag_i;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic [T-1:0]   tag_o;
  logic           yumi_i;
  logic           mul_ready_i, mul_v_o, mul_signed_o;
  logic [W-1:0]   mul_opA_o, mul_opB_o;
  logic           mul_v_i, mul_yumi_o;
  logic [2*W-1:0] mul_result_i;

  int n_checks = 0;
  int n_fails  = 0;

  logic [1:0]   nxt_op;
  logic [W-1:0] nxt_a, nxt_b;
  logic [T-1:0] nxt_tag;

  localparam logic [W-1:0] ONES = {W{1'b1}};

  always #5 clk_i = ~clk_i;

  bsg_mul_op_adapter #(.width_p(W), .tag_width_p(T)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .op_i         (op_i),
    .opA_i        (opA_i),
    .opB_i        (opB_i),
    .tag_i        (tag_i),
    .v_o          (v_o),
    .data_o       (data_o),
    .tag_o        (tag_o),
    .yumi_i       (yumi_i),
    .mul_ready_i  (mul_ready_i),
    .mul_v_o      (mul_v_o),
    .mul_opA_o    (mul_opA_o),
    .mul_opB_o    (mul_opB_o),
    .mul_signed_o (mul_signed_o),
    .mul_v_i      (mul_v_i),
    .mul_result_i (mul_result_i),
    .mul_yumi_o   (mul_yumi_o)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Required answer per op, straight from the arithmetic definition of each op.
  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] ax, bx, p;
    ax = (op == 2'd1 || op == 2'd2) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = (op == 2'd1)               ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ax * bx;
    return (op == 2'd0) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Stand-in for the iterative multiplier: full product, signed or unsigned.
  function automatic logic [2*W-1:0] mock_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sgn);
    logic [2*W-1:0] ax, bx;
    ax = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ax * bx;
  endfunction

  function automatic logic [W-1:0] rand_word();
    unique case ($urandom_range(0, 5))
      0:       return ONES;
      1:       return '0;
      2:       return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One full transaction, entered and left at a negedge with the DUT in IDLE.
  // With chain set, the next request (nxt_*) is presented during the yumi cycle.
  task automatic run_txn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tg, input int rd, input int lat, input int yd,
                         input bit chain);
    logic [W-1:0]   exp_d;
    logic [2*W-1:0] prod;
    exp_d = ref_result(op, a, b);

    check("idle_ready", ready_o, 1);
    check("idle_no_issue", mul_v_o, 0);
    v_i = 1'b1; op_i = op; opA_i = a; opB_i = b; tag_i = tg;
    @(negedge clk_i);
    v_i = 1'b0; opA_i = ~a; opB_i = ~b; tag_i = ~tg; op_i = ~op;

    check("issue_v", mul_v_o, 1);
    check("issue_opA", mul_opA_o, a);
    check("issue_opB", mul_opB_o, b);
    check("issue_signed", mul_signed_o, (op == 2'd1));
    check("issue_not_ready", ready_o, 0);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk_i);
      check("issue_hold", mul_v_o, 1);
    end

    mul_ready_i = 1'b1;
    prod = mock_mul(mul_opA_o, mul_opB_o, mul_signed_o);
    @(negedge clk_i);
    mul_ready_i = 1'b0;
    check("wait_no_issue", mul_v_o, 0);

    for (int i = 0; i < lat; i++) begin
      yumi_i = 1'b1; v_i = 1'b1;
      #1;
      check("wait_no_yumi", mul_yumi_o, 0);
      @(negedge clk_i);
      yumi_i = 1'b0; v_i = 1'b0;
      check("wait_no_v", v_o, 0);
      check("wait_opA_stable", mul_opA_o, a);
      check("wait_opB_stable", mul_opB_o, b);
    end

    mul_v_i = 1'b1; mul_result_i = prod;
    #1;
    check("wait_yumi", mul_yumi_o, 1);
    @(negedge clk_i);
    mul_v_i = 1'b0; mul_result_i = {$urandom, $urandom, $urandom, $urandom};
    check("after_wait_yumi_low", mul_yumi_o, 0);

    if (op == 2'd2) begin
      check("corr_visited", v_o, 0);
      @(negedge clk_i);
    end

    check("out_v", v_o, 1);
    check("out_data", data_o, exp_d);
    check("out_tag", tag_o, tg);
    for (int i = 0; i < yd; i++) begin
      v_i = 1'($urandom_range(0, 1)); opA_i = {$urandom, $urandom};
      @(negedge clk_i);
      check("bp_v", v_o, 1);
      check("bp_data", data_o, exp_d);
      check("bp_tag", tag_o, tg);
      check("bp_not_ready", ready_o, 0);
    end

    yumi_i = 1'b1;
    if (chain) begin
      v_i = 1'b1; op_i = nxt_op; opA_i = nxt_a; opB_i = nxt_b; tag_i = nxt_tag;
    end else begin
      v_i = 1'b0;
    end
    @(negedge clk_i);
    yumi_i = 1'b0;
    check("done_v_low", v_o, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, ready_o, 1);
    check({pfx, "_v_o"}, v_o, 0);
    check({pfx, "_mul_v"}, mul_v_o, 0);
    check({pfx, "_mul_yumi"}, mul_yumi_o, 0);
    check({pfx, "_signed"}, mul_signed_o, 0);
    check({pfx, "_data"}, data_o, 0);
    check({pfx, "_tag"}, tag_o, 0);
    check({pfx, "_opA"}, mul_opA_o, 0);
    check({pfx, "_opB"}, mul_opB_o, 0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    v_i = 1'b0; op_i = '0; opA_i = '0; opB_i = '0; tag_i = '0;
    yumi_i = 1'b0; mul_ready_i = 1'b0; mul_v_i = 1'b0; mul_result_i = '0;
    #2;
    check_reset_outputs("rst_pre_clk");
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst_clocked");
    #2 reset_n_i = 1'b1;
    @(negedge clk_i);

    run_txn(2'd0, 64'd3, 64'd5, 4'h5, 0, 2, 0, 1'b0);
    run_txn(2'd1, ONES, ONES, 4'h1, 1, 0, 1, 1'b0);
    run_txn(2'd0, ONES, ONES, 4'h2, 0, 1, 0, 1'b0);
    run_txn(2'd2, ONES, 64'd2, 4'h3, 2, 3, 0, 1'b0);
    run_txn(2'd2, 64'd1, ONES, 4'h4, 0, 0, 0, 1'b0);
    run_txn(2'd3, ONES, ONES, 4'h6, 0, 1, 0, 1'b0);
    check("mulhu_literal", data_o, 64'hFFFF_FFFF_FFFF_FFFE);

    nxt_op = 2'd3; nxt_a = 64'h1234_5678_9ABC_DEF0; nxt_b = 64'hFEDC_BA98_7654_3210; nxt_tag = 4'hA;
    run_txn(2'd0, 64'd7, 64'd9, 4'h7, 0, 1, 10, 1'b1);
    check("no_accept_in_yumi_cycle", mul_v_o, 0);
    run_txn(nxt_op, nxt_a, nxt_b, nxt_tag, 0, 2, 0, 1'b0);

    // Abandon a MULH mid-WAIT with a reset edge well away from the clock.
    v_i = 1'b1; op_i = 2'd1; opA_i = 64'hDEAD; opB_i = 64'hBEEF; tag_i = 4'hC;
    @(negedge clk_i);
    v_i = 1'b0; mul_ready_i = 1'b1;
    @(negedge clk_i);
    mul_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("pre_rst_signed", mul_signed_o, 1);
    #3 reset_n_i = 1'b0;
    #1;
    check_reset_outputs("rst_mid_wait");
    @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("post_rst_no_resp", v_o, 0);
      check("post_rst_ready", ready_o, 1);
    end
    run_txn(2'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd100, 4'hD, 1, 1, 1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      run_txn(2'($urandom_range(0, 3)), rand_word(), rand_word(), T'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
